// File: rtl/uart_rec_pkg.sv
// Shared types and defaults for the UART record framing path.
// Holds the framer state encoding and the record geometry defaults.
package uart_rec_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } frame_state_e;

  localparam int          RECORD_BYTES_DEF = 32;
  localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

endpackage

// File: rtl/uart_record_frame_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_record_frame_ctrl.sv
// Record framer: hunts sync, streams bytes into packer lanes,
// commits or drops complete records, aborts on inter-byte gaps.
module uart_record_frame_ctrl
  import uart_rec_pkg::*;
#(
  parameter int         RECORD_BYTES = RECORD_BYTES_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         GAP_CYCLES   = 10000,
  parameter int         CNT_W        = 16,
  localparam int        IW = $clog2(RECORD_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic             stat_clr,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             pk_wr_en,
  output logic [IW-1:0]    pk_wr_idx,
  output logic [7:0]       pk_wr_data,
  output logic             pk_commit,
  input  logic             pk_busy,
  output logic [1:0]       st_state,
  output logic [CNT_W-1:0] stat_ok,
  output logic [CNT_W-1:0] stat_drop,
  output logic [CNT_W-1:0] stat_abort
);

  localparam int TW = $clog2(GAP_CYCLES);

  frame_state_e  state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [TW-1:0] timer, timer_d;
  logic          wr_en_d, commit_d;
  logic [IW-1:0] wr_idx_d;
  logic [7:0]    wr_data_d;
  logic          inc_ok, inc_drop, inc_abort;
  logic          is_sync;

  assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
  assign st_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      idx        <= '0;
      timer      <= '0;
      pk_wr_en   <= 1'b0;
      pk_wr_idx  <= '0;
      pk_wr_data <= '0;
      pk_commit  <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      timer      <= timer_d;
      pk_wr_en   <= wr_en_d;
      pk_wr_idx  <= wr_idx_d;
      pk_wr_data <= wr_data_d;
      pk_commit  <= commit_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    timer_d   = timer;
    wr_en_d   = 1'b0;
    wr_idx_d  = pk_wr_idx;
    wr_data_d = pk_wr_data;
    commit_d  = 1'b0;
    inc_ok    = 1'b0;
    inc_drop  = 1'b0;
    inc_abort = 1'b0;
    if (!cfg_enable) begin
      state_d = HUNT;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state)
        HUNT, COMMIT: begin
          if (state == COMMIT) begin
            commit_d = !pk_busy;
            inc_ok   = !pk_busy;
            inc_drop = pk_busy;
          end
          state_d = HUNT;
          idx_d   = '0;
          timer_d = '0;
          // a sync byte landing in the commit cycle opens the next record
          if (is_sync) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = '0;
            wr_data_d = rx_data;
            idx_d     = IW'(1);
            state_d   = COLLECT;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = idx;
            wr_data_d = rx_data;
            timer_d   = '0;
            idx_d     = idx + IW'(1);
            if (idx == IW'(RECORD_BYTES - 1)) begin
              idx_d   = '0;
              state_d = COMMIT;
            end
          end else if (timer == TW'(GAP_CYCLES - 1)) begin
            inc_abort = 1'b1;
            idx_d     = '0;
            timer_d   = '0;
            state_d   = HUNT;
          end else begin
            timer_d = timer + TW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ok (
    .clk(clk), .rst_n(rst_n), .inc(inc_ok),
    .clr(stat_clr), .q(stat_ok)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop (
    .clk(clk), .rst_n(rst_n), .inc(inc_drop),
    .clr(stat_clr), .q(stat_drop)
  );

  sat_counter #(.CNT_W(CNT_W)) u_abort (
    .clk(clk), .rst_n(rst_n), .inc(inc_abort),
    .clr(stat_clr), .q(stat_abort)
  );

endmodule
